// File: rtl/binary_attn_pkg.sv
// binary_attn_pkg: shared sizing and state encoding for the binary attention block.
package binary_attn_pkg;
    localparam int SEQ_LEN = 30;
    localparam int D_MODEL = 16;
    localparam int SCORE_W = $clog2(D_MODEL + 1);
    typedef enum logic {LOAD = 1'b0, COMPUTE = 1'b1} state_t;
endpackage

// File: rtl/xnor_popcount.sv
// xnor_popcount: number of bit positions where a and b agree.
module xnor_popcount #(
    parameter int D_MODEL = 16,
    parameter int SCORE_W = $clog2(D_MODEL + 1)
) (
    input  logic [D_MODEL-1:0] a,
    input  logic [D_MODEL-1:0] b,
    output logic [SCORE_W-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < D_MODEL; i++) count = count + SCORE_W'(~(a[i] ^ b[i]));
    end
endmodule

// File: rtl/binary_attention.sv
// binary_attention: buffers a sequence of binary Q/K/V tokens, then for each query
// emits the value of the best-agreeing key, scanning one key per cycle.
module binary_attention
    import binary_attn_pkg::*;
#(
    parameter int SEQ_LEN = binary_attn_pkg::SEQ_LEN,
    parameter int D_MODEL = binary_attn_pkg::D_MODEL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_MODEL-1:0] query_in,
    input  logic [D_MODEL-1:0] key_in,
    input  logic [D_MODEL-1:0] value_in,
    input  logic               qkv_valid,
    input  logic               qkv_done,
    output logic [D_MODEL-1:0] attn_out,
    output logic               attn_out_valid,
    output logic               busy,
    output logic               done,
    output logic               drop_err
);
    localparam int SW = $clog2(D_MODEL + 1);
    localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CW = $clog2(SEQ_LEN + 1);

    logic [D_MODEL-1:0] q_mem [SEQ_LEN];
    logic [D_MODEL-1:0] k_mem [SEQ_LEN];
    logic [D_MODEL-1:0] v_mem [SEQ_LEN];
    state_t             state, state_next;
    logic [CW-1:0]      wr_cnt;
    logic [IW-1:0]      qi, kj, best_idx, sel_idx, n_last;
    logic [SW-1:0]      score, best_score;
    logic               done_q, done_rise, load_go, row_end, seq_end, better;

    xnor_popcount #(.D_MODEL(D_MODEL), .SCORE_W(SW)) u_pop (
        .a(q_mem[qi]),
        .b(k_mem[kj]),
        .count(score)
    );

    assign done_rise = qkv_done & ~done_q;
    assign n_last    = IW'(wr_cnt - CW'(1));
    assign row_end   = kj == n_last;
    assign seq_end   = row_end && qi == n_last;
    assign better    = score > best_score;
    assign sel_idx   = better ? kj : best_idx;
    // a token arriving with the done edge is stored first, so it makes wr_cnt nonzero
    assign load_go   = (qkv_valid && wr_cnt == CW'(SEQ_LEN - 1)) ||
                       (done_rise && (wr_cnt != '0 || qkv_valid));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= LOAD;
        else state <= state_next;

    always_comb state_next = (state == LOAD) ? (load_go ? COMPUTE : LOAD) : (seq_end ? LOAD : COMPUTE);

    always_comb busy = state == COMPUTE;

    always_ff @(posedge clk)
        if (state == LOAD && qkv_valid) begin
            q_mem[IW'(wr_cnt)] <= query_in;
            k_mem[IW'(wr_cnt)] <= key_in;
            v_mem[IW'(wr_cnt)] <= value_in;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            attn_out       <= '0;
            attn_out_valid <= 1'b0;
            done           <= 1'b0;
            drop_err       <= 1'b0;
            done_q         <= 1'b0;
            wr_cnt         <= '0;
            qi             <= '0;
            kj             <= '0;
            best_idx       <= '0;
            best_score     <= '0;
        end else begin
            done_q         <= qkv_done;
            attn_out_valid <= 1'b0;
            done           <= 1'b0;
            if (state == LOAD) begin
                if (qkv_valid) wr_cnt <= wr_cnt + CW'(1);
            end else begin
                drop_err <= drop_err | qkv_valid;
                if (row_end) begin
                    attn_out       <= v_mem[sel_idx];
                    attn_out_valid <= 1'b1;
                    done           <= seq_end;
                    best_score     <= '0;
                    best_idx       <= '0;
                    kj             <= '0;
                    qi             <= seq_end ? '0 : qi + IW'(1);
                    if (seq_end) wr_cnt <= '0;
                end else begin
                    kj <= kj + IW'(1);
                    if (better) begin
                        best_score <= score;
                        best_idx   <= kj;
                    end
                end
            end
        end
endmodule

// File: doc/binary_attention.md
BINARY_ATTENTION -- requirements
Module: binary_attention

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 30: maximum tokens buffered per sequence.
REQ-002 SHALL have parameter D_MODEL, default 16: bit width of the binary Q/K/V vectors.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port query_in, input, D_MODEL: binary query of the current token.
REQ-006 SHALL have port key_in, input, D_MODEL: binary key of the current token.
REQ-007 SHALL have port value_in, input, D_MODEL: binary value of the current token.
REQ-008 SHALL have port qkv_valid, input, 1: Q/K/V inputs valid this cycle.
REQ-009 SHALL have port qkv_done, input, 1: level end-of-sequence from the QKV projector; only its rising edge acts.
REQ-010 SHALL have port attn_out, output, D_MODEL: value selected for the current query.
REQ-011 SHALL have port attn_out_valid, output, 1: one-cycle strobe qualifying attn_out.
REQ-012 SHALL have port busy, output, 1: high while in COMPUTE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse with the last attn_out_valid of a sequence.
REQ-014 SHALL have port drop_err, output, 1: sticky flag, set when a token is dropped.

Function
REQ-015 SHALL implement states LOAD and COMPUTE; reset state is LOAD.
REQ-016 In LOAD, each qkv_valid cycle SHALL store query_in, key_in and value_in at index wr_cnt, then increment wr_cnt.
REQ-017 LOAD->COMPUTE SHALL occur on the edge that stores entry SEQ_LEN-1, or on a qkv_done rising edge with wr_cnt>=1; sequence length n = entries stored.
REQ-018 If qkv_valid and a qkv_done rising edge coincide, the token SHALL be stored first; n then includes it.
REQ-019 A qkv_done rising edge with wr_cnt==0 SHALL be ignored.
REQ-020 In COMPUTE, each cycle SHALL evaluate one key kj against the current query qi: score = popcount(~(Q[qi]^K[kj])), range 0..D_MODEL, width $clog2(D_MODEL+1).
REQ-021 The best key SHALL update only on a strictly greater score; on ties the lowest kj wins.
REQ-022 On the cycle evaluating kj=n-1, the next edge SHALL register attn_out=V[best] (including kj=n-1 in the comparison), pulse attn_out_valid, reset best, and advance qi with kj=0.
REQ-023 attn_out_valid pulses SHALL be exactly n cycles apart; the first pulse SHALL come n cycles after COMPUTE entry.
REQ-024 With the n-th output, done SHALL pulse, wr_cnt, qi and kj SHALL clear, and the state SHALL return to LOAD.
REQ-025 qkv_valid during COMPUTE SHALL be dropped and SHALL set drop_err; the computation SHALL be unaffected.
REQ-026 attn_out SHALL hold its last value between strobes.
REQ-027 busy SHALL be high in every COMPUTE cycle and low otherwise.

Reset
REQ-028 rst_n low SHALL asynchronously clear attn_out, attn_out_valid, busy, done, drop_err, all counters and the best score/index, and force LOAD.
REQ-029 Reset mid-COMPUTE SHALL abandon the sequence with no further strobes; buffer contents need not be cleared.
REQ-030 The qkv_done edge detector SHALL reset to 0, so qkv_done high out of reset counts as a rising edge.

Structure
REQ-031 Package binary_attn_pkg SHALL hold SEQ_LEN, D_MODEL, SCORE_W and the state encoding.
REQ-032 Agreement counting SHALL be a combinational sub-module, xnor_popcount (D_MODEL-bit inputs, SCORE_W-bit count).
REQ-033 Q/K/V storage SHALL be register arrays indexed by wr_cnt, qi and kj.

Verification
REQ-034 Reset: all outputs 0, busy 0; qkv_valid after reset stores at index 0.
REQ-035 30 tokens with Q=16'hA5A5, K[7]=16'hA5A5, other K=16'h5A5A, V[i]=i -> 30 strobes of attn_out=16'h0007, 30 cycles apart; done on the 30th; busy drops after it.
REQ-036 All K=16'h00FF, V[i]=i -> every attn_out=16'h0000 (tie resolves to lowest index).
REQ-037 5 tokens, then qkv_done rises -> 5 strobes 5 cycles apart, done on the 5th, return to LOAD.
REQ-038 qkv_valid pulses during COMPUTE -> drop_err=1 and stays 1; attn_out sequence is identical to the run without them.
REQ-039 rst_n low mid-COMPUTE -> outputs 0 immediately, no more strobes; a following 30-token load produces correct results.
